// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/decode/execute/writeback sequencer for the accumulator CPU.
// Define ALU_TIMEOUT_EN to add the WAIT_ALU watchdog (sticky fault, then HALT).
module cpu_ctrl_seq #(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    reset_L,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [OPC_W+ADDR_W-1:0] instr_in,
    output logic [1:0]              alu_op,
    output logic                    start,
    input  logic                    done,
    input  logic                    carry,
    output logic                    reg_we,
    output logic                    sel_out,
    output logic                    carry_flag,
    output logic [ADDR_W-1:0]       pc,
    output logic [2:0]              state,
    output logic                    halted,
    output logic                    illegal,
    output logic                    fault
);
    localparam int unsigned INSTR_W = OPC_W + ADDR_W;

    if (OPC_W < 4) begin : g_bad_opc_w
        $error("cpu_ctrl_seq: OPC_W must be at least 4");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("cpu_ctrl_seq: TIMEOUT must be non-zero");
    end

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_CLC = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_HLT = '1;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                carry_q, carry_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic                mem_req_q, mem_req_d;
    logic                start_q, start_d;
    logic                reg_we_q, reg_we_d;
    logic                sel_out_q, sel_out_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;

    logic [OPC_W-1:0]    opc;
    logic [OPC_W-1:0]    opc_in;
    logic [ADDR_W-1:0]   operand;
    logic                fetch_fire;
    logic                expire;

    assign opc        = ir_q[INSTR_W-1 -: OPC_W];
    assign operand    = ir_q[ADDR_W-1:0];
    assign opc_in     = instr_in[INSTR_W-1 -: OPC_W];
    assign fetch_fire = (state_q == S_FETCH) && mem_req_q && mem_ack;

    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        return (op > OP_CLC) && (op != OP_HLT);
    endfunction

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    assign expire = (state_q == S_WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts WAIT_ALU cycles without done; restarts on every entry.
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q || expire;
        if (state_q != S_WAIT && state_d == S_WAIT) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign expire = 1'b0;
    assign fault  = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            pc_q      <= '0;
            carry_q   <= 1'b0;
            alu_op_q  <= 2'd0;
            mem_req_q <= 1'b0;
            start_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            sel_out_q <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            carry_q   <= carry_d;
            alu_op_q  <= alu_op_d;
            mem_req_q <= mem_req_d;
            start_q   <= start_d;
            reg_we_q  <= reg_we_d;
            sel_out_q <= sel_out_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_fire) state_d = S_DECODE;
            S_DECODE: begin
                if (opc >= OP_ADD && opc <= OP_OR) state_d = S_EXEC;
                else if (opc == OP_HLT)            state_d = S_HALT;
                else                               state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_WAIT;
            S_WAIT: begin
                if (done)        state_d = S_WB;
                else if (expire) state_d = S_HALT;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_comb begin
        ir_d      = ir_q;
        pc_d      = pc_q;
        carry_d   = carry_q;
        alu_op_d  = alu_op_q;
        mem_req_d = (state_d == S_FETCH);
        start_d   = (state_d == S_EXEC);
        reg_we_d  = (state_d == S_WB);
        halted_d  = (state_d == S_HALT);
        sel_out_d = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetch_fire) begin
                    ir_d      = instr_in;
                    sel_out_d = (opc_in == OP_OUT);
                    illegal_d = is_illegal(opc_in);
                end
            end
            S_DECODE: begin
                pc_d = pc_q + ADDR_W'(1);
                if (opc >= OP_ADD && opc <= OP_OR) begin
                    alu_op_d = 2'(opc - OP_ADD);
                    pc_d     = pc_q;
                end
                if (opc == OP_JMP || (opc == OP_JC && carry_q)) pc_d = operand;
                if (opc == OP_CLC) carry_d = 1'b0;
                if (opc == OP_HLT) pc_d = pc_q;
            end
            S_WAIT: begin
                // Only ADD/SUB (alu_op 0/1) update the carry flag.
                if (done && !alu_op_q[1]) carry_d = carry;
            end
            S_WB:    pc_d = pc_q + ADDR_W'(1);
            default: ;
        endcase
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign alu_op     = alu_op_q;
    assign start      = start_q;
    assign reg_we     = reg_we_q;
    assign sel_out    = sel_out_q;
    assign carry_flag = carry_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: randomized instruction stream checked against an instruction-level model.
// Define ALU_TIMEOUT_EN to also exercise the ALU watchdog.
`timescale 1ns/1ps
module tb_cpu_ctrl_seq;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset_L = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [11:0]       instr_in = '0;
    logic [1:0]        alu_op;
    logic              start;
    logic              done = 1'b0;
    logic              carry = 1'b0;
    logic              reg_we;
    logic              sel_out;
    logic              carry_flag;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              halted;
    logic              illegal;
    logic              fault;

    cpu_ctrl_seq #(.OPC_W(OPC_W), .ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
        .clock(clock), .reset_L(reset_L), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .instr_in(instr_in), .alu_op(alu_op), .start(start),
        .done(done), .carry(carry), .reg_we(reg_we), .sel_out(sel_out),
        .carry_flag(carry_flag), .pc(pc), .state(state), .halted(halted),
        .illegal(illegal), .fault(fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: program counter and carry flag.
    logic [ADDR_W-1:0] m_pc = '0;
    logic              m_carry = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0; mem_ack = 1'b0; done = 1'b0; carry = 1'b0; instr_in = '0;
        repeat (2) @(negedge clock);
        check_eq("rst_state",   32'(state), 0);
        check_eq("rst_pc",      32'(pc), 0);
        check_eq("rst_carry",   32'(carry_flag), 0);
        check_eq("rst_strobes", 32'({mem_req, start, reg_we, sel_out}), 0);
        check_eq("rst_flags",   32'({halted, illegal, fault}), 0);
        reset_L = 1'b1;
        m_pc = '0;
        m_carry = 1'b0;
    endtask

    // Handshake one instruction and check the DECODE cycle; returns at the DECODE negedge.
    task automatic fetch_decode(input logic [11:0] instr, input int ack_dly);
        logic [3:0] op;
        int k;
        op = instr[11:8];
        k = 0;
        while (mem_req !== 1'b1 && k < 8) begin
            @(negedge clock);
            k++;
        end
        check_eq("fetch_req", 32'(mem_req), 1);
        for (int i = 0; i < ack_dly; i++) begin
            mem_ack = 1'b0;
            instr_in = 12'($urandom);
            @(negedge clock);
            check_eq("fetch_hold", 32'({state, mem_req}), 32'({3'd0, 1'b1}));
        end
        check_eq("fetch_addr",  32'(mem_addr), 32'(m_pc));
        check_eq("fetch_carry", 32'(carry_flag), 32'(m_carry));
        mem_ack = 1'b1;
        instr_in = instr;
        @(negedge clock);
        mem_ack = $urandom_range(0, 1) == 1;
        instr_in = 12'($urandom);
        check_eq("dec_state",   32'(state), 1);
        check_eq("dec_sel_out", 32'(sel_out), 32'(op == 4'd5));
        check_eq("dec_illegal", 32'(illegal), 32'(op >= 4'd9 && op != 4'hF));
        check_eq("dec_excl",    32'({mem_req, start, reg_we}), 0);
    endtask

    // One full instruction with chosen memory/ALU timing; updates the model.
    task automatic run_instr(input logic [11:0] instr, input int ack_dly, input int alu_lat,
                             input logic alu_c, input logic stray);
        logic [3:0] op;
        logic [7:0] opnd;
        op = instr[11:8];
        opnd = instr[7:0];
        fetch_decode(instr, ack_dly);
        if (op >= 4'd1 && op <= 4'd4) begin
            @(negedge clock);
            mem_ack = 1'b0;
            check_eq("exec_state", 32'(state), 2);
            check_eq("exec_start", 32'(start), 1);
            check_eq("exec_aluop", 32'(alu_op), 32'(op - 4'd1));
            done = stray;
            carry = 1'b0;
            @(negedge clock);
            check_eq("wait_entry", 32'({state, start}), 32'({3'd3, 1'b0}));
            for (int i = 0; i < alu_lat; i++) begin
                done = 1'b0;
                @(negedge clock);
                check_eq("wait_hold", 32'(state), 3);
            end
            done = 1'b1;
            carry = alu_c;
            @(negedge clock);
            done = 1'b0;
            if (op <= 4'd2) m_carry = alu_c;
            check_eq("wb_state",  32'(state), 4);
            check_eq("wb_reg_we", 32'(reg_we), 1);
            check_eq("wb_aluop",  32'(alu_op), 32'(op - 4'd1));
            check_eq("wb_carry",  32'(carry_flag), 32'(m_carry));
            m_pc = m_pc + 8'd1;
            @(negedge clock);
            check_eq("post_wb_pc", 32'(pc), 32'(m_pc));
            check_eq("post_wb_we", 32'(reg_we), 0);
        end else if (op == 4'hF) begin
            @(negedge clock);
            check_eq("hlt_state",  32'(state), 5);
            check_eq("hlt_halted", 32'(halted), 1);
        end else begin
            case (op)
                4'd6:    m_pc = opnd;
                4'd7:    m_pc = m_carry ? opnd : m_pc + 8'd1;
                4'd8:    begin m_carry = 1'b0; m_pc = m_pc + 8'd1; end
                default: m_pc = m_pc + 8'd1;
            endcase
            @(negedge clock);
            check_eq("next_state", 32'(state), 0);
            check_eq("next_pc",    32'(pc), 32'(m_pc));
            check_eq("next_carry", 32'(carry_flag), 32'(m_carry));
            check_eq("next_pulse", 32'({sel_out, illegal}), 0);
        end
        mem_ack = 1'b0;
    endtask

    // Fetch an ALU op and stop at the first WAIT_ALU negedge.
    task automatic enter_wait(input logic [11:0] instr);
        fetch_decode(instr, 0);
        @(negedge clock);
        mem_ack = 1'b0;
        done = 1'b0;
        @(negedge clock);
        check_eq("ew_state", 32'(state), 3);
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] hpc;

        do_reset();

        // Directed cases
        run_instr(12'h100, 0, 2, 1'b1, 1'b0);
        run_instr(12'h72A, 0, 0, 1'b0, 1'b0);
        check_eq("jc_taken", 32'(pc), 32'h2A);
        run_instr(12'h800, 1, 0, 1'b0, 1'b0);
        run_instr(12'h72A, 0, 0, 1'b0, 1'b0);
        check_eq("jc_not_taken", 32'(pc), 32'h2C);
        run_instr(12'h6FF, 0, 0, 1'b0, 1'b0);
        run_instr(12'h000, 0, 0, 1'b0, 1'b0);
        check_eq("pc_wrap", 32'(pc), 0);
        run_instr(12'h955, 0, 0, 1'b0, 1'b0);
        run_instr(12'h000, 5, 0, 1'b0, 1'b0);
        run_instr(12'h200, 0, 1, 1'b0, 1'b1);
        run_instr(12'h500, 2, 0, 1'b0, 1'b0);

        // Random instruction stream (no HLT)
        for (int n = 0; n < 200; n++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr({rop, 8'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 4),
                      1'($urandom), 1'($urandom));
        end

        // Reset in the middle of WAIT_ALU
        run_instr(12'h100, 0, 0, 1'b1, 1'b0);
        enter_wait(12'h200);
`ifdef ALU_TIMEOUT_EN
        repeat (5) @(negedge clock);
`else
        repeat (20) @(negedge clock);
        check_eq("wait_forever", 32'({state, fault}), 32'({3'd3, 1'b0}));
`endif
        #2 reset_L = 1'b0;
        #1;
        check_eq("amid_state", 32'(state), 0);
        check_eq("amid_pc",    32'(pc), 0);
        check_eq("amid_carry", 32'(carry_flag), 0);
        check_eq("amid_strb",  32'({start, reg_we, halted}), 0);
        @(negedge clock);
        reset_L = 1'b1;
        m_pc = '0;
        m_carry = 1'b0;

`ifdef ALU_TIMEOUT_EN
        // done on the 15th WAIT_ALU cycle still completes normally
        enter_wait(12'h100);
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            check_eq("to_hold_a", 32'(state), 3);
        end
        done = 1'b1;
        carry = 1'b1;
        @(negedge clock);
        done = 1'b0;
        check_eq("to_late_done", 32'({state, reg_we, fault}), 32'({3'd4, 1'b1, 1'b0}));
        m_carry = 1'b1;
        m_pc = m_pc + 8'd1;
        @(negedge clock);
        // no done at all: HALT with fault exactly 15 cycles after entry
        enter_wait(12'h300);
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            check_eq("to_hold_b", 32'({state, fault}), 32'({3'd3, 1'b0}));
        end
        @(negedge clock);
        check_eq("to_expire", 32'({state, halted, fault}), 32'({3'd5, 1'b1, 1'b1}));
        repeat (3) @(negedge clock);
        check_eq("to_sticky", 32'(fault), 1);
        do_reset();
`endif

        // HALT is absorbing
        run_instr(12'h6C3, 0, 0, 1'b0, 1'b0);
        run_instr(12'hF00, 0, 0, 1'b0, 1'b0);
        hpc = m_pc;
        for (int i = 0; i < 10; i++) begin
            mem_ack = 1'($urandom);
            done = 1'($urandom);
            @(negedge clock);
            check_eq("halt_hold", 32'({state, halted, mem_req, start, reg_we, pc}),
                     32'({3'd5, 1'b1, 1'b0, 1'b0, 1'b0, hpc}));
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Parametrised successor to the FA4 control FSM. Sequences fetch, decode, execute and writeback for the accumulator CPU.
- Handshakes with instruction memory (req/ack) and with a multi-cycle ALU (start/done).
- Holds the PC and a carry flag. Supports conditional branch on carry and a HALT state.
- Sits between the instruction memory port and the datapath/ALU, and drives all datapath control strobes.

Parameters:
- OPC_W, 4, opcode field width (must be >= 4).
- ADDR_W, 8, PC / branch-target width.
- TIMEOUT, 15, max WAIT_ALU cycles before fault (used only with ALU_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  ADDR_W  fetch address; equals pc.
- mem_ack  in  1  instruction valid this cycle.
- instr_in  in  OPC_W+ADDR_W  {opcode, operand}; sampled only when mem_req && mem_ack.
- alu_op  out  2  0=ADD 1=SUB 2=AND 3=OR; held stable from EXEC through WB.
- start  out  1  one-cycle ALU start pulse.
- done  in  1  ALU complete; sampled only in WAIT_ALU.
- carry  in  1  ALU carry-out; valid with done.
- reg_we  out  1  accumulator write strobe (one cycle).
- sel_out  out  1  output-register load strobe (one cycle).
- carry_flag  out  1  registered carry.
- pc  out  ADDR_W  program counter.
- state  out  3  current state encoding.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- fault  out  1  sticky ALU timeout (constant 0 without ALU_TIMEOUT_EN).

Behaviour:
- Reset (async, reset_L=0):
  - state=FETCH; pc=0; carry_flag=0; IR=0; timeout counter=0.
  - All strobes, halted, illegal and fault = 0.
  - Reset mid-operation aborts immediately; there is no pending-ALU cleanup.
- States: FETCH=0, DECODE=1, EXEC=2, WAIT_ALU=3, WB=4, HALT=5.
- FETCH:
  - mem_req=1.
  - On mem_ack: latch IR <= instr_in, go to DECODE. Otherwise stay.
  - mem_ack outside FETCH is ignored.
- DECODE (opcode = IR upper OPC_W bits, operand = IR lower ADDR_W bits):
  - 0 NOP: pc+1, go to FETCH.
  - 1-4 ADD/SUB/AND/OR: set alu_op = opc-1, go to EXEC.
  - 5 OUT: sel_out=1 for this cycle, pc+1, go to FETCH.
  - 6 JMP: pc=operand, go to FETCH.
  - 7 JC: if carry_flag then pc=operand, else pc+1; go to FETCH.
  - 8 CLC: carry_flag=0, pc+1, go to FETCH.
  - all-ones (0xF at OPC_W=4) HLT: go to HALT.
  - Any other value: illegal=1 for one cycle, treated as NOP.
- EXEC: start=1 for exactly one cycle, then WAIT_ALU. done is not sampled in EXEC.
- WAIT_ALU: stay until done=1.
  - For ADD/SUB: carry_flag <= carry on the done cycle.
  - For AND/OR: carry_flag is unchanged.
  - Then go to WB.
- WB: reg_we=1 for one cycle, pc+1, go to FETCH.
- HALT: absorbing. Outputs idle, halted=1. Only reset exits.
- PC arithmetic is modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0). A jump target equal to the current pc is legal.
- Latency: ALU instruction = 1 (fetch, if ack is immediate) + 1 decode + 1 exec + N wait + 1 wb. NOP/OUT/JMP = 2 cycles with immediate ack.
- At most one of start, reg_we, sel_out, mem_req is high in any cycle.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_ALU and increments each cycle without done.
  - When it reaches TIMEOUT without done: fault=1 (sticky until reset) and go to HALT.
  - done arriving on the same cycle the count reaches TIMEOUT wins (normal WB, no fault).
- Undefined: no counter. WAIT_ALU waits indefinitely and fault is tied to 0.

Test Plan:
- Reset then ADD (instr 0x1_00), ack immediate, done 3 cycles after start with carry=1 -> start pulses once; reg_we 1 cycle after done; carry_flag=1; pc 0->1.
- JC 0x7_2A with carry_flag=1 -> pc=0x2A. After CLC (0x8_00) then JC 0x7_2A at pc=p -> pc=p+1.
- pc=0xFF, NOP -> pc=0x00. Opcode 0x9 -> illegal pulses once, pc increments.
- mem_ack held low 5 cycles in FETCH -> mem_req held high, no state change. Stray done in EXEC -> ignored, FSM still enters WAIT_ALU.
- HLT 0xF_00 -> halted=1 permanently. Assert reset_L=0 mid-WAIT_ALU -> immediate return to FETCH, pc=0, carry_flag=0.
- ALU_TIMEOUT_EN, TIMEOUT=15, done never asserted -> fault=1 and HALT exactly 15 cycles after entering WAIT_ALU. done on cycle 15 -> normal WB, fault=0.
